// File: rtl/spi_flash_ctrl.sv
// spi_flash_ctrl: SPI mode-0 serial flash read controller with sequential next-byte fetch.
// Define SPI_FLASH_FAST_READ_EN for the 0x0B fast-read command with 8 dummy bit periods.
module spi_flash_ctrl #(
   parameter int CLK_DIV = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_r_addr,
   input  logic        req_r_next,
   input  logic [23:0] addr,
   output logic [7:0]  d_out,
   output logic        d_ready,
   output logic        flash_cs_n,
   output logic        flash_sclk,
   output logic        flash_mosi,
   input  logic        flash_miso,
   output logic [2:0]  dbg_state_o
);

   typedef enum logic [2:0] {IDLE, GAP, CMD, ADDR, DUMMY, DATA, READY} state_e;

   localparam int DW = $clog2(2 * CLK_DIV);
   localparam logic [DW-1:0] HALF_END = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] GAP_END  = DW'(2 * CLK_DIV - 1);

`ifdef SPI_FLASH_FAST_READ_EN
   localparam logic [7:0] OPCODE     = 8'h0B;
   localparam state_e     AFTER_ADDR = DUMMY;
`else
   localparam logic [7:0] OPCODE     = 8'h03;
   localparam state_e     AFTER_ADDR = DATA;
`endif

   state_e          state_q, state_d;
   logic [23:0]     addr_q, addr_d;
   logic [31:0]     tx_q, tx_d;
   logic [7:0]      rx_q, rx_d;
   logic [7:0]      d_out_q, d_out_d;
   logic            d_ready_q, d_ready_d;
   logic            cs_n_q, cs_n_d;
   logic            sclk_q, sclk_d;
   logic            mosi_q, mosi_d;
   logic [DW-1:0]   div_q, div_d;
   logic [4:0]      bit_q, bit_d;
   logic            setup_q, setup_d;
   logic [4:0]      last_bit;

   assign d_out       = d_out_q;
   assign d_ready     = d_ready_q;
   assign flash_cs_n  = cs_n_q;
   assign flash_sclk  = sclk_q;
   assign flash_mosi  = mosi_q;
   assign dbg_state_o = state_q;
   assign last_bit    = (state_q == ADDR) ? 5'd23 : 5'd7;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         d_out_q   <= '0;
         d_ready_q <= 1'b0;
         cs_n_q    <= 1'b1;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         div_q     <= '0;
         bit_q     <= '0;
         setup_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         d_out_q   <= d_out_d;
         d_ready_q <= d_ready_d;
         cs_n_q    <= cs_n_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         setup_q   <= setup_d;
      end
   end

   // Every byte run (new command or next byte) starts with one setup cycle with SCLK low.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      d_out_d   = d_out_q;
      d_ready_d = d_ready_q;
      cs_n_d    = cs_n_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      div_d     = div_q;
      bit_d     = bit_q;
      setup_d   = setup_q;
      if (req_r_addr) begin
         state_d   = GAP;
         addr_d    = addr;
         d_ready_d = 1'b0;
         cs_n_d    = 1'b1;
         sclk_d    = 1'b0;
         mosi_d    = 1'b0;
         div_d     = '0;
         bit_d     = '0;
         setup_d   = 1'b0;
      end else begin
         case (state_q)
            GAP: begin
               if (div_q == GAP_END) begin
                  div_d   = '0;
                  cs_n_d  = 1'b0;
                  state_d = CMD;
                  setup_d = 1'b1;
                  tx_d    = {OPCODE, addr_q};
                  mosi_d  = OPCODE[7];
               end else begin
                  div_d = div_q + 1'b1;
               end
            end
            READY: begin
               if (req_r_next) begin
                  d_ready_d = 1'b0;
                  state_d   = DATA;
                  setup_d   = 1'b1;
                  div_d     = '0;
                  bit_d     = '0;
               end
            end
            CMD, ADDR, DUMMY, DATA: begin
               if (setup_q) begin
                  setup_d = 1'b0;
               end else if (div_q != HALF_END) begin
                  div_d = div_q + 1'b1;
               end else begin
                  div_d = '0;
                  if (!sclk_q) begin
                     sclk_d = 1'b1;
                     if (state_q == DATA) rx_d = {rx_q[6:0], flash_miso};
                  end else begin
                     // Falling SCLK ends the bit period and presents the next MOSI bit.
                     sclk_d = 1'b0;
                     tx_d   = {tx_q[30:0], 1'b0};
                     mosi_d = (state_q == CMD || state_q == ADDR) ? tx_q[30] : 1'b0;
                     if (bit_q != last_bit) begin
                        bit_d = bit_q + 1'b1;
                     end else begin
                        bit_d = '0;
                        case (state_q)
                           CMD: state_d = ADDR;
                           ADDR: begin
                              state_d = AFTER_ADDR;
                              mosi_d  = 1'b0;
                           end
                           DUMMY: state_d = DATA;
                           default: begin
                              state_d   = READY;
                              d_out_d   = rx_q;
                              d_ready_d = 1'b1;
                           end
                        endcase
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/spi_flash_ctrl.md
SPI_FLASH_CTRL -- requirements
Module: spi_flash_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 1; clk cycles per SCLK half-period (>=1).
REQ-002 Port clk  input  1  system clock; all logic on rising edge.
REQ-003 Port reset  input  1  one clock; reset is synchronous and active-high.
REQ-004 Port req_r_addr  input  1  one-cycle pulse: start read at addr.
REQ-005 Port req_r_next  input  1  one-cycle pulse: fetch next sequential byte.
REQ-006 Port addr  input  24  flash byte address, sampled in the req_r_addr cycle.
REQ-007 Port d_out  output  8  last byte read.
REQ-008 Port d_ready  output  1  d_out valid; controller waiting in READY.
REQ-009 Ports flash_cs_n, flash_sclk, flash_mosi  output  1 each  SPI master pins; flash_miso input 1.

Function
REQ-010 SPI mode 0, MSB first: SCLK idles low; MOSI changes only while SCLK low; MISO sampled on SCLK rising edge.
REQ-011 Each bit = 2*CLK_DIV clk cycles: CLK_DIV low, then CLK_DIV high.
REQ-012 States: IDLE, GAP, CMD (8 bits), ADDR (24 bits), DUMMY (8 bits, macro only), DATA (8 bits), READY.
REQ-013 req_r_addr in any state: latch addr, d_ready<=0, flash_cs_n<=1, SCLK<=0, enter GAP; aborted transfer produces no d_ready.
REQ-014 GAP: cs_n high for 2*CLK_DIV cycles, then cs_n low, enter CMD.
REQ-015 CMD sends opcode 0x03; ADDR sends latched address bits 23..0; DATA shifts 8 MISO bits into a shift register.
REQ-016 After the 8th DATA bit period: d_out<=shift register and d_ready<=1 on the same edge; enter READY with cs_n held low, SCLK low.
REQ-017 Latency req_r_addr to d_ready high = 2*CLK_DIV + 80*CLK_DIV + 1 cycles (83 at CLK_DIV=1).
REQ-018 req_r_next in READY: d_ready<=0 next edge, run DATA again without re-addressing; d_ready rises 16*CLK_DIV+1 cycles after pulse (17 at CLK_DIV=1).
REQ-019 req_r_next outside READY is ignored; req_r_addr and req_r_next in the same cycle: req_r_addr wins.
REQ-020 d_out is stable whenever d_ready=1 and changes only on the d_ready rising edge.
REQ-021 Address wraps 0xFFFFFF->0x000000 via flash-side auto-increment; no controller logic for wrap.
REQ-022 MOSI = 0 outside CMD/ADDR; cs_n never toggles in READY/DATA except on req_r_addr or reset.

Reset
REQ-023 reset: state IDLE, flash_cs_n=1, flash_sclk=0, flash_mosi=0, d_ready=0, d_out=0x00, shift/bit counters 0.
REQ-024 reset during any state ends the transfer; cs_n high from the next edge, no d_ready.
REQ-025 reset dominates req_r_addr/req_r_next in the same cycle.

Configuration
REQ-026 Macro SPI_FLASH_FAST_READ_EN defined: opcode 0x0B, DUMMY state of 8 bit periods (MOSI=0) between ADDR and DATA; first-byte latency 2*CLK_DIV + 96*CLK_DIV + 1 (99 at CLK_DIV=1).
REQ-027 Macro undefined: opcode 0x03, no DUMMY state, latency per REQ-017; req_r_next latency identical in both builds.

Verification (flash model preloaded 0x012345=0xA5, 0x012346=0x3C; CLK_DIV=1)
REQ-028 Assert reset 3 cycles -> cs_n=1, sclk=0, mosi=0, d_ready=0, d_out=0x00.
REQ-029 req_r_addr, addr=0x012345 -> MOSI 0x03,0x01,0x23,0x45; d_ready=1, d_out=0xA5 exactly 83 cycles later.
REQ-030 Then req_r_next -> d_ready=0 next cycle, cs_n stays low, d_ready=1 with d_out=0x3C 17 cycles after pulse.
REQ-031 req_r_addr 0x000000 issued mid-DATA -> cs_n high 2 cycles, new command, no d_ready before new byte at 83 cycles.
REQ-032 req_r_addr (0x012346) and req_r_next same cycle in READY -> full re-address, d_out=0x3C after 83 cycles.
REQ-033 With SPI_FLASH_FAST_READ_EN: addr 0x012345 -> MOSI 0x0B + address + 8 zero bits, d_out=0xA5 after 99 cycles.
